// File: rtl/aibcr3_dll_pkg.sv
// Shared DLL code constants and helpers. The grey-to-thermometer decoder
// testbench uses this package as well.
package aibcr3_dll_pkg;

  localparam int unsigned THM_W = 64;
  localparam int unsigned GRY_W = 7;

  function automatic logic [GRY_W-1:0] bin2gry(input logic [GRY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [GRY_W-1:0] popcnt64(input logic [THM_W-1:0] v);
    logic [GRY_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < THM_W; i++) n = n + GRY_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/aibcr3_dll_thm_bubfix.sv
// Thermometer bubble correction and monotonic check (combinational).
// Majority correction is enabled by defining AIBCR3_DLL_BUBFIX_EN.
module aibcr3_dll_thm_bubfix
  import aibcr3_dll_pkg::*;
(
  input  logic [THM_W-1:0] thm,
  output logic [THM_W-1:0] c,
  output logic             nonmono
);

`ifdef AIBCR3_DLL_BUBFIX_EN
  // Virtual 1 below bit 0 and virtual 0 above bit 63 keep the ends stable.
  logic [THM_W+1:0] ext;
  assign ext = {1'b0, thm, 1'b1};

  always_comb begin
    c = '0;
    for (int unsigned i = 0; i < THM_W; i++)
      c[i] = (ext[i] & ext[i+1]) | (ext[i+1] & ext[i+2]) | (ext[i] & ext[i+2]);
  end
`else
  assign c = thm;
`endif

  // A set bit above a clear bit breaks the 1..10..0 form.
  assign nonmono = |(c[THM_W-1:1] & ~c[THM_W-2:0]);

endmodule

// File: rtl/aibcr3_dll_thm2gry64.sv
// 64-bit thermometer to 7-bit grey converter with stability filter.
// Optional bubble correction: define AIBCR3_DLL_BUBFIX_EN.
module aibcr3_dll_thm2gry64
  import aibcr3_dll_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4
)(
  input  logic             CLKIN,
  input  logic             RSTb,
  input  logic [THM_W-1:0] thm_in,
  input  logic             thm_vld,
  input  logic             err_clr,
  output logic [GRY_W-1:0] grey,
  output logic             grey_vld,
  output logic             lock,
  output logic             bub_err
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  logic [THM_W-1:0] thm_q;
  logic             s1_vld;
  logic [THM_W-1:0] c;
  logic             nonmono;
  logic [GRY_W-1:0] bin_q;
  logic             s2_vld;
  logic [GRY_W-1:0] cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pub_done;
  logic             stable, publish;

  aibcr3_dll_thm_bubfix u_bubfix (
    .thm     (thm_q),
    .c       (c),
    .nonmono (nonmono)
  );

  always_ff @(posedge CLKIN or negedge RSTb) begin
    if (!RSTb) begin
      thm_q  <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= thm_vld;
      if (thm_vld) thm_q <= thm_in;
    end
  end

  always_ff @(posedge CLKIN or negedge RSTb) begin
    if (!RSTb) begin
      bin_q   <= '0;
      s2_vld  <= 1'b0;
      bub_err <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) bin_q <= popcnt64(c);
      if (s1_vld && nonmono) bub_err <= 1'b1;
      else if (err_clr)      bub_err <= 1'b0;
    end
  end

  // Filter decision is folded into one cycle so the publish edge is the
  // same edge on which the count reaches STABLE_CNT.
  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    if (bin_q == cand) begin
      cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end else begin
      cand_nxt = bin_q;
      cnt_nxt  = CNT_W'(1);
    end
    stable  = (cnt_nxt == CNT_MAX);
    publish = s2_vld && stable && (!pub_done || (grey != bin2gry(cand_nxt)));
  end

  always_ff @(posedge CLKIN or negedge RSTb) begin
    if (!RSTb) begin
      cand     <= '0;
      cnt      <= '0;
      lock     <= 1'b0;
      pub_done <= 1'b0;
      grey     <= '0;
      grey_vld <= 1'b0;
    end else begin
      grey_vld <= publish;
      if (s2_vld) begin
        cand <= cand_nxt;
        cnt  <= cnt_nxt;
        lock <= stable;
      end
      if (publish) begin
        grey     <= bin2gry(cand_nxt);
        pub_done <= 1'b1;
      end
    end
  end

endmodule
